seg7_multi_disp: RTL and testbench

Parametrised multi-digit seven-segment display controller for the factorization game. Drives NDIG active-low digits from the game STATE code, the question digits and the player's input digits. Adds a timed digit-by-digit reveal in QUESTION and a blinking cursor digit in INPUT. Sits between the game FSM and the board's HEX pins; all outputs are registered.

---
 rtl/seg7_multi_disp_pkg.sv | 61 ++++++
 rtl/seg7_multi_disp_if.sv | 30 +++
 rtl/seg7_multi_disp_tick.sv | 41 ++++
 rtl/seg7_multi_disp.sv | 122 ++++++++++++
 tb/tb_seg7_multi_disp.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_multi_disp_pkg.sv
// seg7_pkg: shared definitions for the multi-digit seven-segment display.
//   - Game state codes driven by the game FSM.
//   - Active-low segment constants. Each constant is a 7-bit pattern in
//     the order used on the board's HEX pins.
//   - Decoders for BCD question digits and for prime-index input digits.
package seg7_pkg;

    typedef enum logic [3:0] {
        ST_OFF      = 4'b0000,
        ST_READY    = 4'b0010,
        ST_QUESTION = 4'b0011,
        ST_INPUT    = 4'b0100
    } state_e;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_HIDDEN = 7'b1111110;
    localparam logic [6:0] SEG_READY  = 7'b1111011;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;

    // Decimal glyphs. Codes that are not BCD show the hidden bar, so a bad
    // question digit is never mistaken for a real one.
    function automatic logic [6:0] dec_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1011000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_HIDDEN;
        endcase
        return s;
    endfunction

    // Prime-index codes: 0 means "nothing chosen yet" (dash). Codes 1..9
    // select the prime whose decimal glyph is shown. Codes 10..15 are
    // invalid and show the ready glyph.
    function automatic logic [6:0] prime_to_seg(input logic [3:0] p);
        logic [6:0] s;
        case (p)
            4'd0:    s = SEG_DASH;
            4'd1:    s = dec_to_seg(4'd2);
            4'd2:    s = dec_to_seg(4'd3);
            4'd3:    s = dec_to_seg(4'd5);
            4'd4:    s = dec_to_seg(4'd7);
            4'd5:    s = dec_to_seg(4'd1);
            4'd6:    s = dec_to_seg(4'd3);
            4'd7:    s = dec_to_seg(4'd7);
            4'd8:    s = dec_to_seg(4'd9);
            4'd9:    s = dec_to_seg(4'd3);
            default: s = SEG_READY;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_multi_disp_if.sv
// seg7_multi_disp_if: bundle between the game FSM (master) and the display
// controller (slave).
//   state       game state code
//   que         question digits, BCD, nibble k = digit k
//   din         player's prime-index selections, nibble k = digit k
//   cursor      digit being edited while in INPUT
//   nhex        active-low segments, bits [7k+6:7k] = digit k
//   reveal_done all question digits are visible
interface seg7_multi_disp_if #(
    parameter int NDIG = 4
) ();
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [3:0]        state;
    logic [4*NDIG-1:0] que;
    logic [4*NDIG-1:0] din;
    logic [CW-1:0]     cursor;
    logic [7*NDIG-1:0] nhex;
    logic              reveal_done;

    modport master (
        output state, que, din, cursor,
        input  nhex, reveal_done
    );

    modport slave (
        input  state, que, din, cursor,
        output nhex, reveal_done
    );
endinterface

// File: rtl/seg7_multi_disp_tick.sv
// seg7_tick: modulo-DIV counter with synchronous clear.
//   clk, rst_n  clock and asynchronous active-low reset
//   clr_i       restart counting from zero (wins over en_i)
//   en_i        advance the counter this cycle
//   wrap_o      one-cycle pulse on the cycle the counter wraps DIV-1 -> 0
module seg7_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic wrap_o
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // The wrap pulse is combinational so the owner can act on the same edge
    // that returns the counter to zero.
    assign wrap_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seg7_multi_disp.sv
// seg7_multi_disp: multi-digit seven-segment controller for the
// factorization game.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus (slave) state/que/din/cursor in, nhex/reveal_done out
// READY shows the ready glyph on every digit. QUESTION reveals the question
// one digit every REVEAL_DIV cycles. INPUT shows the prime selections, and
// the cursor digit blinks with a half-period of BLINK_DIV cycles.
// All outputs are registered.
module seg7_multi_disp #(
    parameter int NDIG       = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int REVEAL_DIV = 12_500_000
) (
    input logic          clk,
    input logic          rst_n,
    seg7_multi_disp_if.slave bus
);
    import seg7_pkg::*;

    localparam int RW = $clog2(NDIG + 1);
    localparam logic [RW-1:0] NDIG_R = RW'(NDIG);

    logic [3:0]        state_q;
    logic              phase_q, phase_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [7*NDIG-1:0] nhex_q, nhex_d;
    logic              reveal_done_q, reveal_done_d;

    logic              change;
    logic              blink_wrap;
    logic              reveal_en;
    logic              reveal_wrap;
    logic              phase_eff;
    logic [RW-1:0]     rcnt_eff;

    assign change    = (bus.state != state_q);
    assign reveal_en = (bus.state == ST_QUESTION) && (rcnt_q < NDIG_R);

    // On a state-change edge, the pattern is built from the restarted
    // values. This means the first frame of a new state never shows
    // reveal or blink progress left over from the old state.
    assign phase_eff = change ? 1'b1 : phase_q;
    assign rcnt_eff  = change ? '0   : rcnt_q;

    seg7_tick #(.DIV(BLINK_DIV)) u_blink (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (change),
        .en_i   (1'b1),
        .wrap_o (blink_wrap)
    );

    seg7_tick #(.DIV(REVEAL_DIV)) u_reveal (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (change),
        .en_i   (reveal_en),
        .wrap_o (reveal_wrap)
    );

    always_comb begin
        phase_d = phase_q;
        rcnt_d  = rcnt_q;
        if (change) begin
            phase_d = 1'b1;
            rcnt_d  = '0;
        end else begin
            if (blink_wrap) begin
                phase_d = ~phase_q;
            end
            if (reveal_wrap) begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    // Per-digit glyph selection. A cursor at or beyond NDIG matches no digit,
    // so nothing blinks.
    always_comb begin
        nhex_d = '1;
        for (int k = 0; k < NDIG; k++) begin
            case (bus.state)
                ST_READY: begin
                    nhex_d[7*k +: 7] = SEG_READY;
                end
                ST_QUESTION: begin
                    nhex_d[7*k +: 7] = (k < int'(rcnt_eff))
                                       ? dec_to_seg(bus.que[4*k +: 4])
                                       : SEG_HIDDEN;
                end
                ST_INPUT: begin
                    nhex_d[7*k +: 7] = (k == int'(bus.cursor) && !phase_eff)
                                       ? SEG_BLANK
                                       : prime_to_seg(bus.din[4*k +: 4]);
                end
                default: begin
                    nhex_d[7*k +: 7] = SEG_BLANK;
                end
            endcase
        end
        reveal_done_d = (bus.state == ST_QUESTION) && (rcnt_eff == NDIG_R);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= 4'b0000;
            phase_q       <= 1'b1;
            rcnt_q        <= '0;
            nhex_q        <= '1;
            reveal_done_q <= 1'b0;
        end else begin
            state_q       <= bus.state;
            phase_q       <= phase_d;
            rcnt_q        <= rcnt_d;
            nhex_q        <= nhex_d;
            reveal_done_q <= reveal_done_d;
        end
    end

    assign bus.nhex        = nhex_q;
    assign bus.reveal_done = reveal_done_q;
endmodule

// File: tb/tb_seg7_multi_disp.sv
// tb_seg7_multi_disp: directed bench for seg7_multi_disp.
//   u_dut  : NDIG=4, BLINK_DIV=4, REVEAL_DIV=3 (main scenarios)
//   u_dut3 : NDIG=3, used because a 2-bit cursor can reach 3, which is
//            out of range for three digits
module tb_seg7_multi_disp;

    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G2   = 7'b0100100;
    localparam logic [6:0] G3   = 7'b0110000;
    localparam logic [6:0] G4   = 7'b0011001;
    localparam logic [6:0] G7   = 7'b1011000;
    localparam logic [6:0] HID  = 7'b1111110;
    localparam logic [6:0] RDY  = 7'b1111011;
    localparam logic [6:0] BLK  = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;

    localparam logic [3:0] S_OFF = 4'b0000;
    localparam logic [3:0] S_RDY = 4'b0010;
    localparam logic [3:0] S_QUE = 4'b0011;
    localparam logic [3:0] S_INP = 4'b0100;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seg7_multi_disp_if #(.NDIG(4)) bus ();
    seg7_multi_disp_if #(.NDIG(3)) bus3 ();

    seg7_multi_disp #(.NDIG(4), .BLINK_DIV(4), .REVEAL_DIV(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    seg7_multi_disp #(.NDIG(3), .BLINK_DIV(2), .REVEAL_DIV(2)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.state  = S_OFF;
        bus.que    = '0;
        bus.din    = '0;
        bus.cursor = '0;
        bus3.state = S_OFF;
        bus3.que   = '0;
        bus3.din   = '0;
        bus3.cursor = '0;
        #12;
        checks++;
        if (bus.nhex !== 28'hFFFFFFF) begin
            errors++;
            $display("[TB] FAIL reset_nhex got %h want %h", bus.nhex, 28'hFFFFFFF);
        end
        checks++;
        if (bus.reveal_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_done got %b want 0", bus.reveal_done);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.nhex !== 28'hFFFFFFF) begin
            errors++;
            $display("[TB] FAIL off_nhex got %h want %h", bus.nhex, 28'hFFFFFFF);
        end
    endtask

    task automatic test_ready();
        bus.state = S_RDY;
        tick();
        checks++;
        if (bus.nhex !== {RDY, RDY, RDY, RDY}) begin
            errors++;
            $display("[TB] FAIL ready_nhex got %h want %h", bus.nhex, {RDY, RDY, RDY, RDY});
        end
    endtask

    // Output after edge E+m shows floor((m-1)/3) digits (m>=1), capped at 4.
    task automatic test_reveal();
        logic [27:0] exp;
        int          r;
        bus.que   = 16'h4321;
        bus.state = S_QUE;
        tick();
        for (int m = 0; m <= 14; m++) begin
            r = (m == 0) ? 0 : (m - 1) / 3;
            if (r > 4) r = 4;
            exp = {HID, HID, HID, HID};
            if (r > 0) exp[6:0]   = G1;
            if (r > 1) exp[13:7]  = G2;
            if (r > 2) exp[20:14] = G3;
            if (r > 3) exp[27:21] = G4;
            checks++;
            if (bus.nhex !== exp) begin
                errors++;
                $display("[TB] FAIL reveal_nhex m=%0d got %h want %h", m, bus.nhex, exp);
            end
            checks++;
            if (bus.reveal_done !== (r == 4)) begin
                errors++;
                $display("[TB] FAIL reveal_done m=%0d got %b want %b", m, bus.reveal_done, (r == 4));
            end
            tick();
        end
    endtask

    task automatic test_restart();
        bus.state = S_RDY;
        tick();
        bus.state = S_QUE;
        tick();
        for (int m = 1; m <= 8; m++) tick();
        checks++;
        if (bus.nhex !== {HID, HID, G2, G1}) begin
            errors++;
            $display("[TB] FAIL restart_mid got %h want %h", bus.nhex, {HID, HID, G2, G1});
        end
        bus.state = S_RDY;
        tick();
        checks++;
        if (bus.nhex !== {RDY, RDY, RDY, RDY} || bus.reveal_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_leave got %h/%b want %h/0", bus.nhex, bus.reveal_done, {RDY, RDY, RDY, RDY});
        end
        bus.state = S_QUE;
        tick();
        checks++;
        if (bus.nhex !== {HID, HID, HID, HID} || bus.reveal_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_entry got %h/%b want %h/0", bus.nhex, bus.reveal_done, {HID, HID, HID, HID});
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus.nhex !== {HID, HID, HID, HID}) begin
            errors++;
            $display("[TB] FAIL restart_e3 got %h want %h", bus.nhex, {HID, HID, HID, HID});
        end
        tick();
        checks++;
        if (bus.nhex !== {HID, HID, HID, G1}) begin
            errors++;
            $display("[TB] FAIL restart_e4 got %h want %h", bus.nhex, {HID, HID, HID, G1});
        end
    endtask

    // The cursor digit is lit after E..E+4, dark after E+5..E+8, then it
    // alternates every 4 edges.
    task automatic test_input_blink();
        logic [27:0] exp;
        logic        on;
        bus.din    = 16'h0A41;
        bus.cursor = 2'd1;
        bus.state  = S_INP;
        tick();
        for (int m = 0; m <= 16; m++) begin
            on  = (m == 0) || ((((m - 1) / 4) % 2) == 0);
            exp = {DASH, RDY, (on ? G7 : BLK), G2};
            checks++;
            if (bus.nhex !== exp) begin
                errors++;
                $display("[TB] FAIL input_blink m=%0d got %h want %h", m, bus.nhex, exp);
            end
            tick();
        end
    endtask

    task automatic test_cursor_oob();
        bus3.din    = 12'hA41;
        bus3.cursor = 2'd3;
        bus3.state  = S_INP;
        tick();
        for (int m = 0; m < 8; m++) begin
            checks++;
            if (bus3.nhex !== {RDY, G7, G2}) begin
                errors++;
                $display("[TB] FAIL cursor_oob m=%0d got %h want %h", m, bus3.nhex, {RDY, G7, G2});
            end
            tick();
        end
    endtask

    task automatic test_bad_bcd_and_reset();
        bus.state = S_RDY;
        tick();
        bus.que   = 16'hC321;
        bus.state = S_QUE;
        tick();
        for (int m = 1; m <= 13; m++) tick();
        checks++;
        if (bus.nhex !== {HID, G3, G2, G1} || bus.reveal_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_bcd got %h/%b want %h/1", bus.nhex, bus.reveal_done, {HID, G3, G2, G1});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.nhex !== 28'hFFFFFFF) begin
            errors++;
            $display("[TB] FAIL async_reset_nhex got %h want %h", bus.nhex, 28'hFFFFFFF);
        end
        checks++;
        if (bus.reveal_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_done got %b want 0", bus.reveal_done);
        end
        bus.state = S_OFF;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ready();
        test_reveal();
        test_restart();
        test_input_blink();
        test_cursor_oob();
        test_bad_bcd_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
